// File: rtl/weights_loader_wr.sv
// Streams a row-major weight matrix into addressed register-file writes, tracking count and checksum.
// Latency: write issued 1 cycle after accept; done pulses 2 cycles after the final accept.
module weights_loader_wr #(
  parameter int ROWS   = 20,
  parameter int COLS   = 20,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_row_o,
  output logic [ADDR_W-1:0] wr_col_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LAST} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]   wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d, checksum_q, checksum_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_en_q, wr_en_d, done_q, done_d;
  logic                accept;

  assign in_ready_o = (state_q == S_LOAD) && !abort_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_LOAD;
          row_d      = '0;
          col_d      = '0;
          count_d    = '0;
          checksum_d = '0;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (accept) begin
          wr_en_d    = 1'b1;
          wr_row_d   = row_q;
          wr_col_d   = col_q;
          wr_data_d  = in_data_i;
          count_d    = count_q + CNT_W'(1);
          checksum_d = checksum_q + in_data_i;
          if (col_q == ADDR_W'(COLS - 1)) begin
            col_d = '0;
            // Last column of the last row closes the matrix.
            if (row_q == ADDR_W'(ROWS - 1)) begin
              row_d   = '0;
              state_d = S_LAST;
            end else begin
              row_d = row_q + ADDR_W'(1);
            end
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end
      end
      S_LAST: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign wr_en_o    = wr_en_q;
  assign wr_row_o   = wr_row_q;
  assign wr_col_o   = wr_col_q;
  assign wr_data_o  = wr_data_q;
  assign count_o    = count_q;
  assign checksum_o = checksum_q;

endmodule

// File: tb/tb_weights_loader_wr.sv
// Directed bench for weights_loader_wr: full loads, gapped stream, abort, stray start, mid-load reset.
module tb_weights_loader_wr;

  localparam int ROWS = 20;
  localparam int COLS = 20;

  logic        clk = 1'b0;
  logic        rst_i, start_i, abort_i, in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o, wr_en_o, busy_o, done_o;
  logic [4:0]  wr_row_o, wr_col_o;
  logic [31:0] wr_data_o, checksum_o;
  logic [8:0]  count_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sum;

  weights_loader_wr dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .wr_en_o(wr_en_o), .wr_row_o(wr_row_o), .wr_col_o(wr_col_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic with_abort);
    start_i = 1'b1;
    abort_i = with_abort;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    sum     = '0;
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_count", 32'(count_o), 32'd0);
    chk("start_checksum", checksum_o, 32'd0);
    chk("start_wr_en", 32'(wr_en_o), 32'd0);
  endtask

  // Streams words 0..n-1; ones selects 0xFFFFFFFF data, toggle inserts an idle cycle after each word.
  task automatic load_words(input int n, input bit toggle, input bit ones, input int start_at);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d          = ones ? 32'hFFFF_FFFF : 32'(i);
      in_valid_i = 1'b1;
      in_data_i  = d;
      start_i    = (i == start_at);
      #1;
      chk("in_ready_load", 32'(in_ready_o), 32'd1);
      step();
      start_i = 1'b0;
      sum     = sum + d;
      chk("wr_en", 32'(wr_en_o), 32'd1);
      chk("wr_row", 32'(wr_row_o), 32'(i / COLS));
      chk("wr_col", 32'(wr_col_o), 32'(i % COLS));
      chk("wr_data", wr_data_o, d);
      chk("count", 32'(count_o), 32'(i + 1));
      chk("checksum_run", checksum_o, sum);
      chk("done_mid", 32'(done_o), 32'd0);
      chk("busy_mid", 32'(busy_o), 32'd1);
      if (toggle && i != n - 1) begin
        in_valid_i = 1'b0;
        in_data_i  = 32'hDEAD_BEEF;
        step();
        chk("gap_wr_en", 32'(wr_en_o), 32'd0);
        chk("gap_wr_data_hold", wr_data_o, d);
        chk("gap_done", 32'(done_o), 32'd0);
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic finish_load(input logic [31:0] exp_sum);
    chk("last_in_ready", 32'(in_ready_o), 32'd0);
    chk("last_busy", 32'(busy_o), 32'd1);
    chk("last_done", 32'(done_o), 32'd0);
    step();
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_wr_en", 32'(wr_en_o), 32'd0);
    chk("done_count", 32'(count_o), 32'd400);
    chk("done_checksum", checksum_o, exp_sum);
    step();
    chk("done_clear", 32'(done_o), 32'd0);
    chk("checksum_hold", checksum_o, exp_sum);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    sum = '0;
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_checksum", checksum_o, 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    rst_i = 1'b0;
    step();

    // Idle: valid data is not accepted without a start
    in_valid_i = 1'b1; in_data_i = 32'h55;
    #1;
    chk("idle_in_ready", 32'(in_ready_o), 32'd0);
    step();
    in_valid_i = 1'b0;
    chk("idle_wr_en", 32'(wr_en_o), 32'd0);
    chk("idle_count", 32'(count_o), 32'd0);

    // 1: back-to-back stream of 0..399
    do_start(1'b0);
    load_words(400, 1'b0, 1'b0, -1);
    finish_load(32'h0001_37B8);

    // 2: gapped stream
    do_start(1'b0);
    load_words(400, 1'b1, 1'b0, -1);
    finish_load(32'h0001_37B8);

    // 3: abort after 150 accepts, then restart with abort also high (start wins)
    do_start(1'b0);
    load_words(150, 1'b0, 1'b0, -1);
    abort_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'd999;
    #1;
    chk("abort_in_ready", 32'(in_ready_o), 32'd0);
    step();
    abort_i = 1'b0; in_valid_i = 1'b0;
    chk("abort_wr_en", 32'(wr_en_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_count", 32'(count_o), 32'd150);
    chk("abort_checksum", checksum_o, 32'h0000_2BA7);
    step();
    chk("abort_no_done", 32'(done_o), 32'd0);
    chk("abort_count_hold", 32'(count_o), 32'd150);
    do_start(1'b1);
    load_words(400, 1'b0, 1'b0, -1);
    finish_load(32'h0001_37B8);

    // 4: all-ones words wrap the checksum
    do_start(1'b0);
    load_words(400, 1'b0, 1'b1, -1);
    finish_load(32'hFFFF_FE70);

    // 5: stray start at word 37 is ignored
    do_start(1'b0);
    load_words(400, 1'b0, 1'b0, 37);
    finish_load(32'h0001_37B8);

    // 6: asynchronous reset at word 200, then a clean load
    do_start(1'b0);
    load_words(200, 1'b0, 1'b0, -1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_wr_en", 32'(wr_en_o), 32'd0);
    chk("arst_wr_row", 32'(wr_row_o), 32'd0);
    chk("arst_wr_col", 32'(wr_col_o), 32'd0);
    chk("arst_wr_data", wr_data_o, 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_checksum", checksum_o, 32'd0);
    chk("arst_in_ready", 32'(in_ready_o), 32'd0);
    step();
    rst_i = 1'b0;
    chk("arst_done", 32'(done_o), 32'd0);
    step();
    do_start(1'b0);
    load_words(400, 1'b0, 1'b0, -1);
    finish_load(32'h0001_37B8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
